// File: rtl/adpll_mod_ser_pkg.sv
// Shared constants and types for the ADPLL modulation serializer.
package adpll_mod_ser_pkg;

  localparam int unsigned MOD_CTRL   = 0;
  localparam int unsigned MOD_CMD    = 1;
  localparam int unsigned MOD_DIV    = 2;
  localparam int unsigned MOD_TXDATA = 3;
  localparam int unsigned MOD_STATUS = 4;

  localparam int unsigned CMD_FLUSH = 0;
  localparam int unsigned CMD_CLR   = 1;

  // STATUS flag positions, relative to the end of the FIFO level field
  localparam int unsigned ST_EMPTY_OFS = 0;
  localparam int unsigned ST_FULL_OFS  = 1;
  localparam int unsigned ST_BUSY_OFS  = 2;
  localparam int unsigned ST_OVF_OFS   = 3;
  localparam int unsigned ST_UDR_OFS   = 4;

  localparam int unsigned DIV_DEFAULT = 31;

  typedef struct packed {
    logic idle_bit;
    logic lsb_first;
    logic enable;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{idle_bit: 1'b0, lsb_first: 1'b1, enable: 1'b0};

  typedef enum logic {IDLE, SHIFT} mod_state_e;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/adpll_byte_fifo.sv
// Byte FIFO clocked on the falling edge; flush clears contents and wins over push.
module adpll_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wr_data,
  output logic [7:0]    data,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LW'(DEPTH));
    level    = level_q;
    data     = mem_q[rd_ptr_q];
    do_pop   = pop & ~empty;
    // A pop on the same edge frees the slot a full-FIFO push needs
    do_push  = push & (~full | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(negedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/adpll_mod_ser.sv
// CPU-fed byte serializer producing the ADPLL data_mod stream with a programmable bit period.
module adpll_mod_ser
  import adpll_mod_ser_pkg::*;
#(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              data_mod,
  output logic              bit_stb,
  output logic              busy
);

  localparam int unsigned FL = $clog2(FIFO_DEPTH) + 1;

  mod_state_e       state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             ovf_q, ovf_d, udr_q, udr_d;
  logic             ready_q, data_mod_q, data_mod_d, bit_stb_q, bit_stb_d, busy_q, busy_d;

  logic             wr, wr_tx, flush, clr, load, udr_set;
  logic [7:0]       fifo_data;
  logic [FL-1:0]    fifo_level;
  logic             fifo_empty, fifo_full;
  logic [FL+4:0]    status;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[DATA_W-1:8];

  adpll_byte_fifo #(.DEPTH(FIFO_DEPTH), .LW(FL)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (wr_tx),
    .pop    (load),
    .flush  (flush),
    .wr_data(wdata[7:0]),
    .data   (fifo_data),
    .level  (fifo_level),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Register writes and sticky flags; a set on the same edge beats a clear
  always_comb begin
    wr     = valid & wstrb;
    wr_tx  = wr & (address == ADDR_W'(MOD_TXDATA));
    flush  = wr & (address == ADDR_W'(MOD_CMD)) & wdata[CMD_FLUSH];
    clr    = wr & (address == ADDR_W'(MOD_CMD)) & wdata[CMD_CLR];
    ctrl_d = ctrl_q;
    div_d  = div_q;
    if (wr && address == ADDR_W'(MOD_CTRL)) ctrl_d = ctrl_t'(wdata[2:0]);
    if (wr && address == ADDR_W'(MOD_DIV))  div_d  = wdata[DIV_W-1:0];
    ovf_d = (ovf_q & ~clr) | (wr_tx & fifo_full & ~load & ~flush);
    udr_d = (udr_q & ~clr) | udr_set;
  end

  // Serializer FSM: the byte is stored pre-reversed so bits always leave from index 0 up
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    data_mod_d = data_mod_q;
    bit_stb_d  = 1'b0;
    busy_d     = busy_q;
    load       = 1'b0;
    udr_set    = 1'b0;
    case (state_q)
      IDLE: begin
        data_mod_d = ctrl_q.idle_bit;
        busy_d     = 1'b0;
        if (ctrl_q.enable && !fifo_empty) load = 1'b1;
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (idx_q != 3'd7) begin
          idx_d      = idx_q + 3'd1;
          cnt_d      = div_q;
          data_mod_d = sh_q[idx_d];
          bit_stb_d  = 1'b1;
        end else if (ctrl_q.enable && !fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d    = IDLE;
          data_mod_d = ctrl_q.idle_bit;
          busy_d     = 1'b0;
          udr_set    = ctrl_q.enable;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      sh_d       = ctrl_q.lsb_first ? fifo_data : bit_rev8(fifo_data);
      idx_d      = 3'd0;
      cnt_d      = div_q;
      data_mod_d = sh_d[0];
      bit_stb_d  = 1'b1;
      busy_d     = 1'b1;
      state_d    = SHIFT;
    end
  end

  always_comb begin
    status                  = '0;
    status[FL-1:0]          = fifo_level;
    status[FL+ST_EMPTY_OFS] = fifo_empty;
    status[FL+ST_FULL_OFS]  = fifo_full;
    status[FL+ST_BUSY_OFS]  = busy_q;
    status[FL+ST_OVF_OFS]   = ovf_q;
    status[FL+ST_UDR_OFS]   = udr_q;
    case (address)
      ADDR_W'(MOD_CTRL):   rdata = DATA_W'(ctrl_q);
      ADDR_W'(MOD_CMD):    rdata = '0;
      ADDR_W'(MOD_DIV):    rdata = DATA_W'(div_q);
      ADDR_W'(MOD_TXDATA): rdata = '0;
      ADDR_W'(MOD_STATUS): rdata = DATA_W'(status);
      default:             rdata = '1;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ctrl_q     <= CTRL_RESET;
      div_q      <= DIV_W'(DIV_DEFAULT);
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      ovf_q      <= 1'b0;
      udr_q      <= 1'b0;
      ready_q    <= 1'b0;
      data_mod_q <= 1'b0;
      bit_stb_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      ovf_q      <= ovf_d;
      udr_q      <= udr_d;
      ready_q    <= valid;
      data_mod_q <= data_mod_d;
      bit_stb_q  <= bit_stb_d;
      busy_q     <= busy_d;
    end
  end

  assign ready    = ready_q;
  assign data_mod = data_mod_q;
  assign bit_stb  = bit_stb_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_adpll_mod_ser.sv
// Directed bench for adpll_mod_ser with a bit-level scoreboard on data_mod/bit_stb.
module tb_adpll_mod_ser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] wdata = '0;
  logic        wstrb = 1'b0;
  logic [31:0] rdata;
  logic        ready, data_mod, bit_stb, busy;

  typedef struct {
    logic b;
    int   gap;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   last_stb = 0;

  adpll_mod_ser dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata),
    .ready   (ready),
    .data_mod(data_mod),
    .bit_stb (bit_stb),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    valid = 1'b1; wstrb = 1'b1; address = a; wdata = d;
    @(posedge clk);
    valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(posedge clk);
    address = a;
    #1 check(tag, rdata, exp);
  endtask

  task automatic expect_byte(input logic [7:0] v, input bit lsb, input int per, input bit first);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b   = lsb ? v[i] : v[7-i];
      e.gap = (first && i == 0) ? 0 : per;
      exp_q.push_back(e);
    end
  endtask

  task automatic busy_span(input int limit, output int n);
    int t;
    t = 0;
    n = 0;
    while (busy !== 1'b1 && t < limit) begin @(posedge clk); t++; end
    while (busy === 1'b1 && n < limit) begin @(posedge clk); n++; end
  endtask

  // Scoreboard: every strobe consumes one expected bit and its spacing from the previous strobe
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (bit_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("stb_extra", 32'(bit_stb), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("bit_val", 32'(data_mod), 32'(e.b));
        if (e.gap != 0) check("bit_gap", 32'(cyc - last_stb), 32'(e.gap));
      end
      last_stb = cyc;
    end
  end

  initial begin
    int n, t;
    #1 rst = 1'b1;
    @(posedge clk);
    check("rst_data_mod", 32'(data_mod), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_bit_stb", 32'(bit_stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    rst = 1'b0;

    @(posedge clk);
    valid = 1'b1; wstrb = 1'b0; address = 3'd0;
    #1 check("ready_lag", 32'(ready), 32'd0);
    check("rd_ctrl", rdata, 32'h2);
    @(posedge clk);
    #1 check("ready_set", 32'(ready), 32'd1);
    valid = 1'b0;
    @(posedge clk);
    #1 check("ready_clr", 32'(ready), 32'd0);
    check_reg("rd_cmd", 3'd1, 32'h0);
    check_reg("rd_div", 3'd2, 32'd31);
    check_reg("rd_tx", 3'd3, 32'h0);
    check_reg("rd_status", 3'd4, 32'h10);
    check_reg("rd_unmapped", 3'd5, 32'hFFFF_FFFF);

    // LSB-first 0xA5 at the default 32-cycle bit period
    bus_write(3'd3, 32'hA5);
    expect_byte(8'hA5, 1'b1, 32, 1'b1);
    bus_write(3'd0, 32'h3);
    busy_span(1000, n);
    check("a5_busy_len", 32'(n), 32'd256);
    check("a5_sb_drained", 32'(exp_q.size()), 32'd0);
    check_reg("a5_status", 3'd4, 32'h110);

    // MSB-first, DIV=3, two back-to-back bytes, idle level high
    bus_write(3'd1, 32'h2);
    bus_write(3'd0, 32'h4);
    bus_write(3'd2, 32'd3);
    bus_write(3'd3, 32'h81);
    bus_write(3'd3, 32'h3C);
    check("idle_high", 32'(data_mod), 32'd1);
    expect_byte(8'h81, 1'b0, 4, 1'b1);
    expect_byte(8'h3C, 1'b0, 4, 1'b0);
    bus_write(3'd0, 32'h5);
    busy_span(1000, n);
    check("two_byte_len", 32'(n), 32'd64);
    check("two_byte_drained", 32'(exp_q.size()), 32'd0);
    check_reg("two_byte_status", 3'd4, 32'h110);
    check("idle_after", 32'(data_mod), 32'd1);

    // Overflow, clear flags, flush
    bus_write(3'd0, 32'h2);
    bus_write(3'd1, 32'h2);
    for (int i = 0; i < 9; i++) bus_write(3'd3, 32'(8'h10 + i));
    check_reg("ovf_status", 3'd4, 32'hA8);
    bus_write(3'd1, 32'h2);
    check_reg("clr_status", 3'd4, 32'h28);
    bus_write(3'd1, 32'h1);
    check_reg("flush_status", 3'd4, 32'h10);

    // Disable during bit 3 of the first byte; second byte stays queued
    bus_write(3'd3, 32'h5A);
    bus_write(3'd3, 32'hC3);
    expect_byte(8'h5A, 1'b1, 4, 1'b1);
    bus_write(3'd0, 32'h3);
    t = 0;
    while (exp_q.size() > 4 && t < 200) begin @(posedge clk); #1; t++; end
    check("dis_reach_bit3", 32'(exp_q.size()), 32'd4);
    bus_write(3'd0, 32'h2);
    busy_span(1000, n);
    check_reg("dis_status", 3'd4, 32'h01);
    check("dis_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during bit 5
    bus_write(3'd1, 32'h1);
    bus_write(3'd3, 32'hFF);
    expect_byte(8'hFF, 1'b1, 4, 1'b1);
    bus_write(3'd0, 32'h3);
    t = 0;
    while (exp_q.size() > 2 && t < 200) begin @(posedge clk); #1; t++; end
    check("pre_rst_bits", 32'(exp_q.size()), 32'd2);
    check("pre_rst_stb", 32'(bit_stb), 32'd1);
    check("pre_rst_data", 32'(data_mod), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_data_mod", 32'(data_mod), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_bit_stb", 32'(bit_stb), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    rst = 1'b0;
    check_reg("post_rst_ctrl", 3'd0, 32'h2);
    check_reg("post_rst_div", 3'd2, 32'd31);
    check_reg("post_rst_status", 3'd4, 32'h10);
    repeat (10) @(posedge clk);
    check("post_rst_idle", 32'(data_mod), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
